// File: rtl/project_pkg.sv
// Shared types and defaults for the multi-cycle sequencer of the 8-bit core.
package project_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_IMM    = 3'd3,
        ST_EXEC   = 3'd4,
        ST_MEM    = 3'd5,
        ST_WB     = 3'd6,
        ST_HALT   = 3'd7
    } e_seq_state;

    localparam int unsigned ACK_TIMEOUT_DEF = 15;
    localparam int unsigned CNT_W_DEF       = 16;
    localparam int unsigned WDOG_W          = 8;

endpackage

// File: rtl/seq_watchdog.sv
// Memory-ack watchdog: counts consecutive unacknowledged request cycles and
// pulses timeout_o on the cycle the count reaches ACK_TIMEOUT.
module seq_watchdog
    import project_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic timeout_o
);

    localparam logic [WDOG_W-1:0] LAST = WDOG_W'(ACK_TIMEOUT - 1);

    logic [WDOG_W-1:0] cnt_q, cnt_d;

    assign timeout_o = en_i && !clr_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || timeout_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Phase sequencer for the 8-bit core: shares one memory port between fetch,
// immediate fetch and load/store, and gates decode signals into phase strobes.
//
// state  | meaning
// IDLE   | out of reset, one dead cycle
// FETCH  | read opcode at PC into IR
// DECODE | decode settles, no strobes
// IMM    | read trailing immediate byte at PC
// EXEC   | ALU / branch resolve
// MEM    | data load or store at ALU address
// WB     | register-file write
// HALT   | parked; bus error or halt request
module multicycle_sequencer
    import project_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ctl_reg_wr,
    input  logic             ctl_mem_wr,
    input  logic             ctl_mem_to_reg,
    input  logic             ctl_pc_src,
    input  logic             ctl_rimm,
    input  logic             halt_i,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_we,
    output logic             imm_we,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             reg_we,
    output logic             halted,
    output logic             bus_err,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] retired
);

    e_seq_state       state_q, state_d;
    logic             pending_q, pending_d;
    logic             bus_err_q, bus_err_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             timeout;
    logic             halt_now;
    logic             mem_done;
    logic             retire;

    // A fetch may only yield to halt before its request has gone out.
    assign halt_now = halt_i && !pending_q;
    assign mem_done = mem_req && mem_ack;

    seq_watchdog #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (!mem_req || mem_ack),
        .en_i     (mem_req),
        .timeout_o(timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
            bus_err_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            bus_err_q <= bus_err_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = halt_i ? ST_HALT : ST_FETCH;
            ST_FETCH: begin
                if (halt_now || timeout) state_d = ST_HALT;
                else if (mem_done)       state_d = ST_DECODE;
            end
            ST_DECODE: state_d = ctl_rimm ? ST_IMM : ST_EXEC;
            ST_IMM: begin
                if (timeout)       state_d = ST_HALT;
                else if (mem_done) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (ctl_mem_wr || ctl_mem_to_reg) state_d = ST_MEM;
                else if (ctl_pc_src)              state_d = ST_FETCH;
                else if (ctl_reg_wr)              state_d = ST_WB;
                else                              state_d = ST_FETCH;
            end
            ST_MEM: begin
                if (timeout)       state_d = ST_HALT;
                else if (mem_done) state_d = (ctl_mem_to_reg && !ctl_mem_wr) ? ST_WB : ST_FETCH;
            end
            ST_WB:     state_d = ST_FETCH;
            ST_HALT: begin
                if (!halt_i && !bus_err_q) state_d = ST_FETCH;
            end
            default:   state_d = ST_IDLE;
        endcase

        pending_d = mem_req && !mem_ack && !timeout;
        bus_err_d = bus_err_q || timeout;
        retire    = (state_d == ST_FETCH) &&
                    ((state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB));
        retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire};
    end

    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        ir_we    = 1'b0;
        imm_we   = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        reg_we   = 1'b0;
        halted   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req = !halt_now;
                ir_we   = !halt_now && mem_ack;
                pc_inc  = !halt_now && mem_ack;
            end
            ST_IMM: begin
                mem_req = 1'b1;
                imm_we  = mem_ack;
                pc_inc  = mem_ack;
            end
            ST_EXEC:  pc_load = ctl_pc_src && !(ctl_mem_wr || ctl_mem_to_reg);
            ST_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = ctl_mem_wr;
            end
            ST_WB:    reg_we = 1'b1;
            ST_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    assign bus_err = bus_err_q;
    assign state_o = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: instruction table, hand-written
// halt/watchdog sequences and random instructions against a phase-list model.
module tb_multicycle_sequencer;

    localparam int CNT_W = 16;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_IMM = 3'd3,
                           S_EXEC = 3'd4, S_MEM = 3'd5, S_WB = 3'd6, S_HALT = 3'd7;

    // {mem_req, mem_we, addr_sel, ir_we, imm_we, pc_inc, pc_load, reg_we, halted}
    localparam logic [8:0] REQ = 9'h100, WE = 9'h080, ASEL = 9'h040, IRW = 9'h020,
                           IMMW = 9'h010, PCI = 9'h008, PCL = 9'h004, RWE = 9'h002,
                           HLT = 9'h001;

    logic clk = 1'b0;
    logic rst_n;
    logic ctl_reg_wr, ctl_mem_wr, ctl_mem_to_reg, ctl_pc_src, ctl_rimm, halt_i, mem_ack;
    logic mem_req, mem_we, addr_sel, ir_we, imm_we, pc_inc, pc_load, reg_we, halted, bus_err;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] retired;

    multicycle_sequencer #(.ACK_TIMEOUT(15), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ctl_reg_wr(ctl_reg_wr), .ctl_mem_wr(ctl_mem_wr), .ctl_mem_to_reg(ctl_mem_to_reg),
        .ctl_pc_src(ctl_pc_src), .ctl_rimm(ctl_rimm), .halt_i(halt_i), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
        .imm_we(imm_we), .pc_inc(pc_inc), .pc_load(pc_load), .reg_we(reg_we),
        .halted(halted), .bus_err(bus_err), .state_o(state_o), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] st;
        logic [8:0] o;
        logic       ack;
    } step_t;

    typedef struct {
        logic reg_wr, mem_wr, mem_to_reg, pc_src, rimm;
        int   wf, wi, wm;
        int   exp_cycles;
    } vec_t;

    step_t sched[$];
    int    n_pass = 0;
    int    n_total = 0;
    int    exp_retired = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [8:0] outs();
        return {mem_req, mem_we, addr_sel, ir_we, imm_we, pc_inc, pc_load, reg_we, halted};
    endfunction

    function automatic vec_t mk(logic rw, logic mw, logic m2r, logic ps, logic ri,
                                int wf, int wi, int wm, int cyc);
        vec_t v;
        v.reg_wr = rw; v.mem_wr = mw; v.mem_to_reg = m2r; v.pc_src = ps; v.rimm = ri;
        v.wf = wf; v.wi = wi; v.wm = wm; v.exp_cycles = cyc;
        return v;
    endfunction

    function automatic void push(logic [2:0] st, logic [8:0] o, logic ack);
        step_t s;
        s.st = st; s.o = o; s.ack = ack;
        sched.push_back(s);
    endfunction

    // Expected phase list of one instruction: memory phases are wait cycles then an ack cycle.
    function automatic void build(vec_t v);
        logic       is_mem;
        logic [8:0] mo;
        sched.delete();
        repeat (v.wf) push(S_FETCH, REQ, 1'b0);
        push(S_FETCH, REQ | IRW | PCI, 1'b1);
        push(S_DECODE, 9'h0, 1'b0);
        if (v.rimm) begin
            repeat (v.wi) push(S_IMM, REQ, 1'b0);
            push(S_IMM, REQ | IMMW | PCI, 1'b1);
        end
        is_mem = v.mem_wr || v.mem_to_reg;
        push(S_EXEC, (!is_mem && v.pc_src) ? PCL : 9'h0, 1'b0);
        if (is_mem) begin
            mo = REQ | ASEL | (v.mem_wr ? WE : 9'h0);
            repeat (v.wm) push(S_MEM, mo, 1'b0);
            push(S_MEM, mo, 1'b1);
            if (v.mem_to_reg && !v.mem_wr) push(S_WB, RWE, 1'b0);
        end else if (!v.pc_src && v.reg_wr) begin
            push(S_WB, RWE, 1'b0);
        end
    endfunction

    // Entered just after a rising edge with the DUT in FETCH.
    task automatic run_instr(input vec_t v, input int halt_from, input string tag, output int cycles);
        int               k;
        bit               done;
        logic [CNT_W-1:0] r_prev;
        build(v);
        ctl_reg_wr = v.reg_wr; ctl_mem_wr = v.mem_wr; ctl_mem_to_reg = v.mem_to_reg;
        ctl_pc_src = v.pc_src; ctl_rimm = v.rimm;
        r_prev = retired;
        k = 0;
        done = 0;
        while (!done && k < 40) begin
            mem_ack = (k < sched.size()) ? sched[k].ack : 1'b0;
            halt_i  = (halt_from >= 0 && k >= halt_from);
            @(negedge clk);
            if (k < sched.size()) begin
                check({tag, " state"}, 32'(state_o), 32'(sched[k].st));
                check({tag, " strobes"}, 32'(outs()), 32'(sched[k].o));
            end
            @(posedge clk); #1;
            k++;
            if (retired != r_prev) done = 1;
        end
        mem_ack = 1'b0;
        exp_retired++;
        check({tag, " cycles"}, 32'(k), 32'(sched.size()));
        check({tag, " retired"}, 32'(retired), 32'(exp_retired % 65536));
        check({tag, " next FETCH"}, 32'(state_o), 32'(S_FETCH));
        cycles = k;
    endtask

    // DUT in FETCH with halt_i high and nothing outstanding: park, then resume.
    task automatic halt_then_resume(input string tag);
        halt_i = 1'b1;
        @(negedge clk);
        check({tag, " fetch holds off"}, 32'(state_o), 32'(S_FETCH));
        check({tag, " no request"}, 32'(outs()), 32'(9'h0));
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, " halt state"}, 32'(state_o), 32'(S_HALT));
        check({tag, " halt strobes"}, 32'(outs()), 32'(HLT));
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, " stays halted"}, 32'(state_o), 32'(S_HALT));
        @(posedge clk); #1;
        halt_i = 1'b0;
        @(posedge clk); #1;
        check({tag, " resumes"}, 32'(state_o), 32'(S_FETCH));
        check({tag, " retired kept"}, 32'(retired), 32'(exp_retired % 65536));
        check({tag, " no bus_err"}, 32'(bus_err), 32'(0));
    endtask

    initial begin
        vec_t tbl[8];
        vec_t v;
        int   cyc;
        int   kind;

        tbl[0] = mk(1, 0, 0, 0, 0, 0, 0, 0, 4);  // ADD 0x14
        tbl[1] = mk(1, 0, 1, 0, 0, 0, 0, 3, 8);  // LW 0x74, 3 wait cycles in MEM
        tbl[2] = mk(0, 1, 0, 0, 0, 0, 0, 0, 4);  // SW 0x84
        tbl[3] = mk(0, 0, 0, 1, 1, 0, 0, 0, 4);  // JEQ 0xC0 taken, immediate
        tbl[4] = mk(0, 0, 0, 0, 1, 0, 0, 0, 4);  // JEQ 0xC0 not taken
        tbl[5] = mk(0, 0, 0, 1, 0, 0, 0, 0, 3);  // jump, no immediate
        tbl[6] = mk(1, 0, 1, 0, 0, 0, 0, 0, 5);  // LW, 0-wait
        tbl[7] = mk(1, 0, 0, 0, 1, 2, 1, 0, 8);  // ALU with immediate, slow memory

        rst_n = 1'b0;
        ctl_reg_wr = 0; ctl_mem_wr = 0; ctl_mem_to_reg = 0; ctl_pc_src = 0; ctl_rimm = 0;
        halt_i = 0; mem_ack = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset state", 32'(state_o), 32'(S_IDLE));
        check("reset strobes", 32'(outs()), 32'(9'h0));
        check("reset retired", 32'(retired), 32'(0));
        check("reset bus_err", 32'(bus_err), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("idle cycle state", 32'(state_o), 32'(S_IDLE));
        check("idle cycle strobes", 32'(outs()), 32'(9'h0));
        @(posedge clk); #1;
        check("idle to fetch", 32'(state_o), 32'(S_FETCH));

        for (int i = 0; i < 8; i++) begin
            run_instr(tbl[i], -1, $sformatf("tbl%0d", i), cyc);
            check($sformatf("tbl%0d latency", i), 32'(cyc), 32'(tbl[i].exp_cycles));
        end

        // Halt raised in EXEC of an ADD: WB completes first.
        run_instr(tbl[0], 2, "halt_exec", cyc);
        halt_then_resume("halt_exec");

        // Halt raised while a fetch request is outstanding is deferred.
        v = mk(0, 0, 0, 0, 0, 2, 0, 0, 5);
        run_instr(v, 1, "halt_pending", cyc);
        check("halt_pending latency", 32'(cyc), 32'(v.exp_cycles));
        halt_then_resume("halt_pending");

        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 4);
            v = mk($urandom_range(0, 1), 0, 0, $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), 0);
            case (kind)
                0: begin v.reg_wr = 1; v.pc_src = 0; end
                1: v.mem_to_reg = 1;
                2: v.mem_wr = 1;
                3: v.pc_src = 1;
                default: begin v.reg_wr = 0; v.pc_src = 0; end
            endcase
            run_instr(v, -1, $sformatf("rnd%0d", i), cyc);
        end

        // Fetch never acknowledged: watchdog fires on the 15th waiting cycle.
        ctl_reg_wr = 0; ctl_mem_wr = 0; ctl_mem_to_reg = 0; ctl_pc_src = 0; ctl_rimm = 0;
        mem_ack = 0; halt_i = 0;
        repeat (14) begin
            @(posedge clk); #1;
        end
        check("wdog before limit state", 32'(state_o), 32'(S_FETCH));
        check("wdog before limit req", 32'(mem_req), 32'(1));
        check("wdog before limit bus_err", 32'(bus_err), 32'(0));
        @(posedge clk); #1;
        check("wdog fired state", 32'(state_o), 32'(S_HALT));
        check("wdog fired bus_err", 32'(bus_err), 32'(1));
        check("wdog fired strobes", 32'(outs()), 32'(HLT));
        mem_ack = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
        check("bus_err holds halt", 32'(state_o), 32'(S_HALT));
        check("bus_err sticky", 32'(bus_err), 32'(1));
        check("wdog retired kept", 32'(retired), 32'(exp_retired % 65536));
        rst_n = 1'b0;
        #2;
        check("async reset state", 32'(state_o), 32'(S_IDLE));
        check("async reset bus_err", 32'(bus_err), 32'(0));
        check("async reset retired", 32'(retired), 32'(0));
        check("async reset strobes", 32'(outs()), 32'(9'h0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
